ether_cmd_bridge: RTL and testbench

- Sits directly downstream of the Ethernet receive MAC.
- Consumes the 56-bit frame payload pulses produced on successful FCS check.
- Buffers them, decodes each into one Manta bus read or write transaction, and waits for read responses.
- Presents read replies on a ready/valid port for the transmit path.

---
 rtl/ether_pkg.sv | 45 ++++
 rtl/ether_cmd_bridge_fifo.sv | 45 ++++
 rtl/ether_cmd_bridge.sv | 169 ++++++++++++++++
 tb/tb_ether_cmd_bridge.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ether_pkg.sv
// Shared definitions for the Ethernet command bridge: payload field layout,
// opcodes, reply layout and the bridge FSM state type.
package ether_pkg;

    localparam int PAYLOAD_W = 56;
    localparam int REPLY_W   = 48;

    localparam int TAG_LSB  = 40;
    localparam int OP_LSB   = 32;
    localparam int ADDR_LSB = 16;
    localparam int DATA_LSB = 0;

    localparam logic [7:0] OP_READ  = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;

    typedef struct packed {
        logic [15:0] tag;
        logic [15:0] addr;
        logic [15:0] data;
    } reply_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        REPLY
    } state_t;

    function automatic logic [15:0] payload_tag(input logic [PAYLOAD_W-1:0] p);
        return p[TAG_LSB +: 16];
    endfunction

    function automatic logic [7:0] payload_op(input logic [PAYLOAD_W-1:0] p);
        return p[OP_LSB +: 8];
    endfunction

    function automatic logic [15:0] payload_addr(input logic [PAYLOAD_W-1:0] p);
        return p[ADDR_LSB +: 16];
    endfunction

    function automatic logic [15:0] payload_data(input logic [PAYLOAD_W-1:0] p);
        return p[DATA_LSB +: 16];
    endfunction

endpackage

// File: rtl/ether_cmd_bridge_fifo.sv
// Synchronous FIFO with full/empty flags; a read and a write in the same cycle
// are allowed even when full, since the read frees the slot the write needs.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // The extra pointer bit separates full (wrapped once more) from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ether_cmd_bridge.sv
// Turns received frame payloads into single bus read/write transactions and
// returns read results (or timeout errors) on a ready/valid reply port.
module ether_cmd_bridge
    import ether_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PAYLOAD_W-1:0] payload_in,
    input  logic                 payload_valid,
    output logic [15:0]          bus_addr_o,
    output logic [15:0]          bus_data_o,
    output logic                 bus_rw_o,
    output logic                 bus_valid_o,
    input  logic [15:0]          bus_data_i,
    input  logic                 bus_valid_i,
    output logic [REPLY_W-1:0]   reply,
    output logic                 reply_err,
    output logic                 reply_valid,
    input  logic                 reply_ready,
    output logic [7:0]           overflow_count,
    output logic [7:0]           bad_op_count
);
    localparam int TIMER_W = $clog2(TIMEOUT + 1) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    state_t               state;
    state_t               state_next;
    logic [PAYLOAD_W-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 dropped;
    logic                 bad_op;
    logic                 rd_done;
    logic                 rd_timeout;
    logic [7:0]           head_op;
    logic [15:0]          hold_tag;
    logic [7:0]           hold_op;
    logic [15:0]          hold_addr;
    logic [TIMER_W-1:0]   timer;
    reply_t               reply_q;

    cmd_fifo #(
        .WIDTH (PAYLOAD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (payload_valid),
        .wr_data (payload_in),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign dropped     = payload_valid && fifo_full && !pop;
    assign head_op     = payload_op(fifo_head);
    assign reply       = reply_q;
    assign reply_valid = (state == REPLY);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        bad_op     = 1'b0;
        rd_done    = 1'b0;
        rd_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (hold_op == OP_READ) begin
                    state_next = WAIT_RD;
                end else begin
                    bad_op     = (hold_op != OP_WRITE);
                    state_next = IDLE;
                end
            end
            WAIT_RD: begin
                // A response in the final waiting cycle still beats the timeout.
                if (bus_valid_i) begin
                    rd_done    = 1'b1;
                    state_next = REPLY;
                end else if (timer >= TIMER_LAST) begin
                    rd_timeout = 1'b1;
                    state_next = REPLY;
                end
            end
            REPLY: begin
                if (reply_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus request is registered at pop time so it is visible exactly during ISSUE.
    always_ff @(posedge clk) begin
        if (rst || !pop) begin
            bus_valid_o <= 1'b0;
            bus_rw_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_data_o  <= '0;
        end else begin
            bus_valid_o <= (head_op == OP_READ) || (head_op == OP_WRITE);
            bus_rw_o    <= (head_op == OP_WRITE);
            bus_addr_o  <= ((head_op == OP_READ) || (head_op == OP_WRITE)) ? payload_addr(fifo_head) : 16'h0;
            bus_data_o  <= (head_op == OP_WRITE) ? payload_data(fifo_head) : 16'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_tag  <= '0;
            hold_op   <= '0;
            hold_addr <= '0;
        end else if (pop) begin
            hold_tag  <= payload_tag(fifo_head);
            hold_op   <= head_op;
            hold_addr <= payload_addr(fifo_head);
        end
    end

    // Timer counts cycles elapsed since the read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (state == ISSUE) begin
            timer <= TIMER_W'(1);
        end else if (state == WAIT_RD) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reply_q   <= '0;
            reply_err <= 1'b0;
        end else if (rd_done) begin
            reply_q   <= '{tag: hold_tag, addr: hold_addr, data: bus_data_i};
            reply_err <= 1'b0;
        end else if (rd_timeout) begin
            reply_q   <= '{tag: hold_tag, addr: hold_addr, data: 16'h0};
            reply_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_count <= '0;
            bad_op_count   <= '0;
        end else begin
            if (dropped && overflow_count != 8'hFF) overflow_count <= overflow_count + 1'b1;
            if (bad_op && bad_op_count != 8'hFF)    bad_op_count   <= bad_op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ether_cmd_bridge.sv
// Self-checking bench for ether_cmd_bridge: directed scenarios followed by
// randomized transactions checked against a transaction-level model.
module tb_ether_cmd_bridge;
    import ether_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [55:0] payload_in;
    logic        payload_valid;
    logic [15:0] bus_addr_o;
    logic [15:0] bus_data_o;
    logic        bus_rw_o;
    logic        bus_valid_o;
    logic [15:0] bus_data_i;
    logic        bus_valid_i;
    logic [47:0] reply;
    logic        reply_err;
    logic        reply_valid;
    logic        reply_ready;
    logic [7:0]  overflow_count;
    logic [7:0]  bad_op_count;

    int checks = 0;
    int errors = 0;
    logic [32:0] bus_log [$];

    ether_cmd_bridge #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .payload_in     (payload_in),
        .payload_valid  (payload_valid),
        .bus_addr_o     (bus_addr_o),
        .bus_data_o     (bus_data_o),
        .bus_rw_o       (bus_rw_o),
        .bus_valid_o    (bus_valid_o),
        .bus_data_i     (bus_data_i),
        .bus_valid_i    (bus_valid_i),
        .reply          (reply),
        .reply_err      (reply_err),
        .reply_valid    (reply_valid),
        .reply_ready    (reply_ready),
        .overflow_count (overflow_count),
        .bad_op_count   (bad_op_count)
    );

    always #5 clk = ~clk;

    // Every bus strobe is one cycle long, so one record per negedge it is high.
    always @(negedge clk) begin
        if (bus_valid_o) bus_log.push_back({bus_rw_o, bus_addr_o, bus_data_o});
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [55:0] p);
        payload_in    = p;
        payload_valid = 1'b1;
        tick();
        payload_valid = 1'b0;
        payload_in    = '0;
    endtask

    function automatic logic [55:0] mk(input logic [15:0] tag, input logic [7:0] op,
                                       input logic [15:0] addr, input logic [15:0] data);
        return {tag, op, addr, data};
    endfunction

    task automatic handshake();
        reply_ready = 1'b1;
        tick();
        reply_ready = 1'b0;
        checkOutput("reply_release", 64'(reply_valid), 64'd0);
    endtask

    logic [55:0] burst [6];
    int          model_bad;

    initial begin
        rst = 1'b1; payload_in = '0; payload_valid = 1'b0;
        bus_data_i = '0; bus_valid_i = 1'b0; reply_ready = 1'b0;
        repeat (3) tick();
        checkOutput("reset_bus", {bus_valid_o, bus_rw_o, bus_addr_o, bus_data_o}, 64'd0);
        checkOutput("reset_reply", {reply_valid, reply_err, reply}, 64'd0);
        checkOutput("reset_counts", {overflow_count, bad_op_count}, 64'd0);
        rst = 1'b0;
        tick();

        // Write: strobe two cycles after the payload, no reply.
        bus_log.delete();
        applyStimulus(mk(16'h0001, OP_WRITE, 16'h1234, 16'hABCD));
        checkOutput("wr_early", 64'(bus_valid_o), 64'd0);
        tick();
        checkOutput("wr_strobe", {bus_valid_o, bus_rw_o, bus_addr_o, bus_data_o},
                    {1'b1, 1'b1, 16'h1234, 16'hABCD});
        tick();
        checkOutput("wr_strobe_end", {bus_valid_o, bus_rw_o, bus_addr_o, bus_data_o}, 64'd0);
        repeat (3) tick();
        checkOutput("wr_pulses", 64'(bus_log.size()), 64'd1);
        checkOutput("wr_no_reply", 64'(reply_valid), 64'd0);

        // Read answered three cycles after the request, reply held while not ready.
        applyStimulus(mk(16'h0007, OP_READ, 16'h0010, 16'hFFFF));
        tick();
        checkOutput("rd_strobe", {bus_valid_o, bus_rw_o, bus_addr_o, bus_data_o},
                    {1'b1, 1'b0, 16'h0010, 16'h0000});
        repeat (3) tick();
        bus_data_i = 16'h5A5A; bus_valid_i = 1'b1;
        tick();
        bus_data_i = 16'h0; bus_valid_i = 1'b0;
        checkOutput("rd_reply", {reply_valid, reply_err, reply}, {1'b1, 1'b0, 48'h0007_0010_5A5A});
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("rd_hold", {reply_valid, reply_err, reply}, {1'b1, 1'b0, 48'h0007_0010_5A5A});
        end
        handshake();

        // Timeout: error reply exactly TMO cycles after the strobe, late response ignored.
        applyStimulus(mk(16'h0042, OP_READ, 16'h0ABC, 16'h0));
        tick();
        checkOutput("tmo_strobe", 64'(bus_valid_o), 64'd1);
        repeat (TMO - 1) tick();
        checkOutput("tmo_early", 64'(reply_valid), 64'd0);
        tick();
        checkOutput("tmo_reply", {reply_valid, reply_err, reply}, {1'b1, 1'b1, 48'h0042_0ABC_0000});
        bus_data_i = 16'h1111; bus_valid_i = 1'b1;
        tick();
        bus_data_i = 16'h0; bus_valid_i = 1'b0;
        tick();
        checkOutput("tmo_late_ignored", {reply_valid, reply_err, reply}, {1'b1, 1'b1, 48'h0042_0ABC_0000});
        handshake();

        // Overflow: six payloads while a reply is stalled, only four fit.
        applyStimulus(mk(16'h0009, OP_READ, 16'h0020, 16'h0));
        tick();
        tick();
        bus_data_i = 16'h1357; bus_valid_i = 1'b1;
        tick();
        bus_data_i = 16'h0; bus_valid_i = 1'b0;
        checkOutput("ovf_stalled", 64'(reply_valid), 64'd1);
        bus_log.delete();
        for (int i = 0; i < 6; i++) begin
            burst[i] = mk(16'(i), OP_WRITE, 16'($urandom), 16'($urandom));
            payload_in = burst[i];
            payload_valid = 1'b1;
            tick();
        end
        payload_valid = 1'b0;
        checkOutput("ovf_count", 64'(overflow_count), 64'd2);
        handshake();
        repeat (12) tick();
        checkOutput("ovf_exec_count", 64'(bus_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (bus_log.size() > 0)
                checkOutput("ovf_exec_order", 64'(bus_log.pop_front()),
                            {31'd0, 1'b1, payload_addr(burst[i]), payload_data(burst[i])});
        end

        // Bad opcode: no strobe, counted, next write still works.
        bus_log.delete();
        applyStimulus(mk(16'h0003, 8'h7F, 16'h4444, 16'h5555));
        repeat (4) tick();
        checkOutput("bad_no_strobe", 64'(bus_log.size()), 64'd0);
        checkOutput("bad_count", 64'(bad_op_count), 64'd1);
        applyStimulus(mk(16'h0004, OP_WRITE, 16'h6666, 16'h7777));
        repeat (3) tick();
        checkOutput("bad_then_write", 64'(bus_log.size()), 64'd1);
        if (bus_log.size() > 0)
            checkOutput("bad_then_write_val", 64'(bus_log[0]), {31'd0, 1'b1, 16'h6666, 16'h7777});

        // Reset during WAIT_RD with a payload still queued behind it.
        applyStimulus(mk(16'h0005, OP_READ, 16'h0030, 16'h0));
        tick();
        tick();
        applyStimulus(mk(16'h0006, OP_WRITE, 16'h0BAD, 16'h0BAD));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_outputs", {bus_valid_o, bus_rw_o, bus_addr_o, bus_data_o, reply_valid, reply_err}, 64'd0);
        checkOutput("rst_reply", {reply, overflow_count, bad_op_count}, 64'd0);
        bus_log.delete();
        repeat (5) tick();
        checkOutput("rst_fifo_empty", 64'(bus_log.size()), 64'd0);
        applyStimulus(mk(16'h0008, OP_WRITE, 16'h00A0, 16'hBEEF));
        repeat (3) tick();
        checkOutput("rst_then_write", 64'(bus_log.size()), 64'd1);
        if (bus_log.size() > 0)
            checkOutput("rst_then_write_val", 64'(bus_log[0]), {31'd0, 1'b1, 16'h00A0, 16'hBEEF});

        // Randomized transactions against the model.
        model_bad = 0;
        for (int i = 0; i < 24; i++) begin
            logic [15:0] tag, addr, data, rdata;
            logic [7:0]  op;
            logic [47:0] got_reply, exp_reply;
            logic        got_err, exp_err;
            int          kind, d, lat, exp_lat;
            kind  = (i < 2) ? 0 : int'($urandom_range(0, 3));
            tag   = 16'($urandom);
            addr  = 16'($urandom);
            data  = 16'($urandom);
            rdata = 16'($urandom);
            op    = (kind <= 1) ? OP_READ : (kind == 2) ? OP_WRITE : 8'($urandom_range(2, 255));
            d     = (i == 0) ? TMO - 1 : (i == 1) ? TMO : int'($urandom_range(1, 10));
            bus_log.delete();
            applyStimulus(mk(tag, op, addr, data));
            tick();
            if (op == OP_READ) begin
                lat = -1;
                got_reply = '0;
                got_err = 1'b0;
                for (int k = 0; k <= 20; k++) begin
                    if (reply_valid && lat < 0) begin
                        lat = k;
                        got_reply = reply;
                        got_err = reply_err;
                    end
                    bus_valid_i = (k == d);
                    bus_data_i  = rdata;
                    tick();
                end
                bus_valid_i = 1'b0;
                bus_data_i  = '0;
                exp_err   = (d >= TMO);
                exp_lat   = exp_err ? TMO : d + 1;
                exp_reply = {tag, addr, exp_err ? 16'h0 : rdata};
                checkOutput("rnd_rd_strobes", 64'(bus_log.size()), 64'd1);
                if (bus_log.size() > 0)
                    checkOutput("rnd_rd_req", 64'(bus_log[0]), {31'd0, 1'b0, addr, 16'h0});
                checkOutput("rnd_rd_latency", 64'(lat), 64'(exp_lat));
                checkOutput("rnd_rd_reply", {got_err, got_reply}, {exp_err, exp_reply});
                checkOutput("rnd_rd_stable", {reply_valid, reply_err, reply}, {1'b1, exp_err, exp_reply});
                handshake();
            end else begin
                for (int k = 0; k < 3; k++) begin
                    reply_ready = 1'($urandom);
                    tick();
                end
                reply_ready = 1'b0;
                if (op == OP_WRITE) begin
                    checkOutput("rnd_wr_strobes", 64'(bus_log.size()), 64'd1);
                    if (bus_log.size() > 0)
                        checkOutput("rnd_wr_req", 64'(bus_log[0]), {31'd0, 1'b1, addr, data});
                end else begin
                    model_bad++;
                    checkOutput("rnd_bad_strobes", 64'(bus_log.size()), 64'd0);
                    checkOutput("rnd_bad_count", 64'(bad_op_count), 64'(model_bad));
                end
                checkOutput("rnd_no_reply", 64'(reply_valid), 64'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
